booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 151 +++++++++++++++
 tb/tb_booth_mult_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier for signed or unsigned operands.
// Operands are widened to WIDTH+1 bits so one datapath covers both signednesses.
// The block runs WIDTH+1 Booth steps, then holds the product until it is acknowledged.
// Optional feature: define BOOTH_EARLY_TERM_EN to finish early once the remaining
// multiplier bits can only produce shifts.
//
// Handshake: the block accepts start only while in_ready=1 (IDLE), on that clock edge.
// The result is offered while valid=1 (DONE). Z and valid stay stable until an edge
// with ack=1, which returns the block to IDLE. start is ignored outside IDLE.
// ack is ignored outside DONE.
module booth_mult_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   Q,
   input  logic [WIDTH-1:0]   M,
   output logic               in_ready,
   output logic               busy,
   output logic [2*WIDTH-1:0] Z,
   output logic               valid,
   input  logic               ack,
   output logic [1:0]         dbg_state_o
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH:0]       qr_q, qr_d;
   logic                 q1_q, q1_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   z_q, z_d;

   // Booth add/subtract result and the arithmetically shifted {A,Q}.
   logic [WIDTH:0]       sum;
   logic [2*WIDTH+1:0]   step_cat;

`ifdef BOOTH_EARLY_TERM_EN
   logic                        et_hit;
   logic signed [2*WIDTH+1:0]   et_shift;
`endif

   // State and datapath registers; reset clears everything so no stale result survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         qr_q    <= '0;
         q1_q    <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         qr_q    <= qr_d;
         q1_q    <= q1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
      end
   end

   // One Booth step: conditional add/subtract of M, then an arithmetic shift of {A,Q}.
   always_comb begin
      sum = a_q;
      case ({qr_q[0], q1_q})
         2'b01:   sum = a_q + m_q;
         2'b10:   sum = a_q - m_q;
         default: sum = a_q;
      endcase
      step_cat = {sum[WIDTH], sum, qr_q[WIDTH:1]};
   end

`ifdef BOOTH_EARLY_TERM_EN
   // Early exit when the unprocessed multiplier bits and q_1 all agree: only shifts remain.
   always_comb begin
      et_hit = 1'b1;
      for (int i = 0; i <= WIDTH; i++) begin
         if ((i <= WIDTH - int'(cnt_q)) && (qr_q[i] != q1_q)) et_hit = 1'b0;
      end
      et_shift = $signed({a_q, qr_q}) >>> (WIDTH + 1 - int'(cnt_q));
   end
`endif

   // Next-state and datapath control for IDLE -> RUN -> DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      qr_d    = qr_q;
      q1_d    = q1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = {is_signed & M[WIDTH-1], M};
               qr_d    = {is_signed & Q[WIDTH-1], Q};
               a_d     = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
            if (et_hit) begin
               a_d     = et_shift[2*WIDTH+1:WIDTH+1];
               qr_d    = et_shift[WIDTH:0];
               cnt_d   = CW'(WIDTH + 1);
               z_d     = et_shift[2*WIDTH-1:0];
               state_d = S_DONE;
            end else begin
`endif
               a_d   = step_cat[2*WIDTH+1:WIDTH+1];
               qr_d  = step_cat[WIDTH:0];
               q1_d  = qr_q[0];
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH)) begin
                  z_d     = step_cat[2*WIDTH-1:0];
                  state_d = S_DONE;
               end
`ifdef BOOTH_EARLY_TERM_EN
            end
`endif
         end
         S_DONE: begin
            if (ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready    = (state_q == S_IDLE);
   assign busy        = (state_q == S_RUN);
   assign valid       = (state_q == S_DONE);
   assign Z           = z_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8 with hand-computed products.
// Define BOOTH_EARLY_TERM_EN on both the bench and the RTL to cover early termination.
module tb_booth_mult_seq;

   localparam int W = 8;
`ifdef BOOTH_EARLY_TERM_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 10;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           is_signed;
   logic [W-1:0]   Q;
   logic [W-1:0]   M;
   logic           in_ready;
   logic           busy;
   logic [2*W-1:0] Z;
   logic           valid;
   logic           ack;
   logic [1:0]     dbg_state;

   int total = 0;
   int bad   = 0;
   int e;
   logic [2*W-1:0] z_hold;

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .Q(Q), .M(M), .in_ready(in_ready), .busy(busy), .Z(Z),
      .valid(valid), .ack(ack), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive one request; edge 1 is the accepting edge. Operands are scrambled afterwards.
   task automatic start_mult(input logic s, input logic [W-1:0] q, input logic [W-1:0] m);
      @(negedge clk);
      is_signed = s; Q = q; M = m; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      is_signed = ~s;
      Q = W'($urandom_range(0, 255));
      M = W'($urandom_range(0, 255));
   endtask

   // Count edges from the accepting edge until valid, with a bounded budget.
   task automatic wait_done(output int edges);
      edges = 1;
      while (!valid && edges < 60) begin
         @(posedge clk);
         edges++;
         #1;
      end
      check("valid_seen", valid, 1);
   endtask

   task automatic finish_ack();
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      check("ack_to_idle", {valid, in_ready}, 2'b01);
   endtask

   task automatic run_chk(input string tag, input logic s, input logic [W-1:0] q,
                          input logic [W-1:0] m, input logic [2*W-1:0] exp_z, input int exp_lat);
      int edges;
      start_mult(s, q, m);
      wait_done(edges);
      check(tag, Z, exp_z);
      if (exp_lat != 0) check({tag, "_lat"}, edges, exp_lat);
      finish_ack();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; Q = '0; M = '0; ack = 1'b0;
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_z", Z, 0);
      check("rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      check("idle_hold", {in_ready, busy, valid}, 3'b100);

      run_chk("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1, LAT);
      run_chk("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, LAT);
      run_chk("s_ffxff", 1'b1, 8'hFF, 8'hFF, 16'h0001, LAT);
      run_chk("s_7fx80", 1'b1, 8'h7F, 8'h80, 16'hC080, LAT);
      run_chk("u_80x80", 1'b0, 8'h80, 8'h80, 16'h4000, LAT);
      run_chk("u_a5x3c", 1'b0, 8'hA5, 8'h3C, 16'h26AC, LAT);
      run_chk("s_5xm3", 1'b1, 8'h05, 8'hFD, 16'hFFF1, LAT);

      // Most negative squared, then hold without ack (start pulses must be ignored).
      start_mult(1'b1, 8'h80, 8'h80);
      wait_done(e);
      check("s_80x80", Z, 16'h4000);
      z_hold = Z;
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         check("hold_z", Z, 16'h4000);
         check("hold_valid", valid, 1);
      end
      start = 1'b0;
      check("hold_z_same", Z, z_hold);
      finish_ack();

      // New request and an ack while busy must both be ignored.
      start_mult(1'b0, 8'h03, 8'h07);
      check("run_busy", {busy, in_ready}, 2'b10);
      start = 1'b1; Q = 8'h0F; M = 8'h0F; ack = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; ack = 1'b0;
      wait_done(e);
      check("busy_ignore_z", Z, 16'h0015);
      finish_ack();
      @(posedge clk);
      #1;
      check("no_second_run", {in_ready, busy, valid}, 3'b100);

      // Asynchronous reset in the middle of RUN.
      start_mult(1'b1, 8'h12, 8'h34);
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", valid, 0);
      check("mid_rst_z", Z, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      run_chk("u_7x6", 1'b0, 8'h07, 8'h06, 16'h002A, LAT);

`ifdef BOOTH_EARLY_TERM_EN
      start_mult(1'b0, 8'h00, 8'h55);
      wait_done(e);
      check("et_zero_z", Z, 0);
      check("et_zero_lat", e, 2);
      finish_ack();
      start_mult(1'b0, 8'h03, 8'h07);
      wait_done(e);
      check("et_3x7_z", Z, 16'h0015);
      check("et_3x7_lt10", e < 10, 1);
      check("et_3x7_lat", e, 5);
      finish_ack();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
